// File: rtl/freq_meter.sv
// Gated strobe counter: counts i_strobe-high cycles over gate_cycles clock edges and reports the total with a one-cycle valid pulse.
// Define FREQ_METER_CONTINUOUS_EN for back-to-back windows. Otherwise each i_start gives one window.
module freq_meter #(
  parameter int count_width = 32,
  parameter int gate_cycles = 25000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_strobe,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [count_width-1:0] o_count,
  output logic                   o_overflow
);

  localparam int gate_width = $clog2(gate_cycles + 1);
  localparam logic [gate_width-1:0] gate_reload = gate_width'(gate_cycles - 1);
  localparam logic [gate_width-1:0] gate_zero   = {gate_width{1'b0}};
  localparam logic [count_width-1:0] count_max  = {count_width{1'b1}};
  localparam logic [count_width-1:0] count_zero = {count_width{1'b0}};

`ifdef FREQ_METER_CONTINUOUS_EN
  localparam bit continuous = 1'b1;
`else
  localparam bit continuous = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, GATE = 1'b1} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [gate_width-1:0]  gate_cnt;
  logic [count_width-1:0] acc;
  logic                   sat;
  logic                   launch;
  logic                   final_edge;
  logic [count_width:0]   sum_wide;
  logic [count_width-1:0] sum_sat;
  logic                   sat_next;

  // Saturating add of the current strobe; a carry out means an event was lost.
  always_comb begin
    sum_wide = {1'b0, acc} + {{count_width{1'b0}}, i_strobe};
    sat_next = sat | sum_wide[count_width];
    if (sum_wide[count_width]) begin
      sum_sat = count_max;
    end else begin
      sum_sat = sum_wide[count_width-1:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort takes priority over both start and window completion.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_start && !i_abort) begin
          next_state = GATE;
        end else begin
          next_state = IDLE;
        end
      end
      GATE: begin
        if (i_abort) begin
          next_state = IDLE;
        end else if (gate_cnt == gate_zero && !continuous) begin
          next_state = IDLE;
        end else begin
          next_state = GATE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Decoded controls for the datapath plus the busy output.
  always_comb begin
    launch     = (state == IDLE) && i_start && !i_abort;
    final_edge = (state == GATE) && !i_abort && (gate_cnt == gate_zero);
    o_busy     = (state == GATE);
  end

  // Gate counter, accumulator and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gate_cnt   <= gate_zero;
      acc        <= count_zero;
      sat        <= 1'b0;
      o_valid    <= 1'b0;
      o_count    <= count_zero;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (launch) begin
        gate_cnt <= gate_reload;
        acc      <= count_zero;
        sat      <= 1'b0;
      end else if (state == GATE && i_abort) begin
        gate_cnt <= gate_zero;
        acc      <= count_zero;
        sat      <= 1'b0;
      end else if (final_edge) begin
        o_count    <= sum_sat;
        o_overflow <= sat_next;
        o_valid    <= 1'b1;
        gate_cnt   <= continuous ? gate_reload : gate_zero;
        acc        <= count_zero;
        sat        <= 1'b0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt - gate_width'(1);
        acc      <= sum_sat;
        sat      <= sat_next;
      end else begin
        gate_cnt <= gate_cnt;
        acc      <= acc;
        sat      <= sat;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances share stimulus and are compared every cycle against a window-level reference model.
module tb_freq_meter;

`ifdef FREQ_METER_CONTINUOUS_EN
  localparam bit cont = 1'b1;
`else
  localparam bit cont = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic        start;
  logic        abort;
  logic        busy [3];
  logic        valid [3];
  logic        ovf [3];
  logic [31:0] count_a;
  logic [2:0]  count_b;
  logic [7:0]  count_c;

  int checks_total;
  int checks_passed;

  // Reference model state, one slot per instance.
  bit     m_active [3];
  int     m_samples [3];
  longint m_sum [3];
  longint m_count [3];
  bit     m_ovf [3];
  bit     m_valid [3];

  freq_meter #(.count_width(32), .gate_cycles(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_start(start), .i_abort(abort),
    .o_busy(busy[0]), .o_valid(valid[0]), .o_count(count_a), .o_overflow(ovf[0]));
  freq_meter #(.count_width(3), .gate_cycles(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_start(start), .i_abort(abort),
    .o_busy(busy[1]), .o_valid(valid[1]), .o_count(count_b), .o_overflow(ovf[1]));
  freq_meter #(.count_width(8), .gate_cycles(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_start(start), .i_abort(abort),
    .o_busy(busy[2]), .o_valid(valid[2]), .o_count(count_c), .o_overflow(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gate_of(int k);
    return (k == 2) ? 1 : 16;
  endfunction

  function automatic longint max_of(int k);
    return (k == 0) ? 64'd4294967295 : ((k == 1) ? 64'd7 : 64'd255);
  endfunction

  function automatic longint count_of(int k);
    return (k == 0) ? longint'(count_a) : ((k == 1) ? longint'(count_b) : longint'(count_c));
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_active[k] = 1'b0; m_samples[k] = 0; m_sum[k] = 0;
      m_count[k] = 0; m_ovf[k] = 1'b0; m_valid[k] = 1'b0;
    end
  endtask

  // One clock edge of the reference: windows accumulate unbounded sums and clip only when reported.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      if (m_active[k]) begin
        if (abort) begin
          m_active[k] = 1'b0;
        end else begin
          m_samples[k]++;
          m_sum[k] += longint'(strobe);
          if (m_samples[k] == gate_of(k)) begin
            m_count[k]  = (m_sum[k] > max_of(k)) ? max_of(k) : m_sum[k];
            m_ovf[k]    = (m_sum[k] > max_of(k));
            m_valid[k]  = 1'b1;
            m_active[k] = cont;
            m_samples[k] = 0;
            m_sum[k]     = 0;
          end
        end
      end else if (start && !abort) begin
        m_active[k] = 1'b1; m_samples[k] = 0; m_sum[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy%0d", k), longint'(busy[k]), longint'(m_active[k]));
      check($sformatf("valid%0d", k), longint'(valid[k]), longint'(m_valid[k]));
      check($sformatf("count%0d", k), count_of(k), m_count[k]);
      check($sformatf("ovf%0d", k), longint'(ovf[k]), longint'(m_ovf[k]));
    end
  endtask

  task automatic cycle(input logic st, input logic ab, input logic sb);
    start = st; abort = ab; strobe = sb;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    checks_total = 0; checks_passed = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; strobe = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_busy", longint'(busy[0]), 0);
    check("rst_count", longint'(count_a), 0);
    check("rst_valid", longint'(valid[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // Full window of ones: 16 on the wide counter, saturated 7 on the 3-bit one.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1);
    check("ones_count", count_of(0), 16);
    check("ones_valid", longint'(valid[0]), 1);
    check("sat_count", count_of(1), 7);
    check("sat_ovf", longint'(ovf[1]), 1);
    cycle(1'b0, 1'b1, 1'b0);

    // Abort coinciding with the final gate edge leaves the previous result.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("abort_final_busy", longint'(busy[0]), 0);
    check("abort_final_valid", longint'(valid[0]), 0);
    check("abort_final_count", count_of(0), 16);
    cycle(1'b1, 1'b1, 1'b1);
    check("start_abort_idle", longint'(busy[0]), 0);

    // Alternating strobe starting high at E1.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
    check("alt_count", count_of(0), 8);
    cycle(1'b0, 1'b1, 1'b0);

    // Quiet window clears the saturation result.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0);
    check("quiet_count", count_of(1), 0);
    check("quiet_ovf", longint'(ovf[1]), 0);
    cycle(1'b0, 1'b1, 1'b0);

    // One start, 16 ones then zeros: continuous builds keep reporting windows.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1);
    check("run1_count", count_of(0), 16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0);
    check("run2_valid", longint'(valid[0]), longint'(cont));
    check("run2_busy", longint'(busy[0]), longint'(cont));
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset partway through a window.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1);

    // Random traffic with a per-window strobe density.
    begin
      int density;
      density = 50;
      for (int i = 0; i < 3000; i++) begin
        logic st;
        logic ab;
        st = ($urandom_range(0, 19) == 0);
        ab = ($urandom_range(0, 79) == 0);
        if (st && !m_active[0]) density = $urandom_range(0, 100);
        cycle(st, ab, ($urandom_range(0, 99) < density) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
